// File: rtl/timer_periph_if.sv
// Bus port bundle for the timer slave: chip-enable, write strobe, byte
// offset, write data and the combinational read data returned upstream.
interface timer_periph_if;
  logic        cs;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer: prescaler, auto-reload up-counter, sticky
// update flag (W1C) and a level interrupt. Registers live at word offsets
// 0x00 CR, 0x04 PSC, 0x08 ARR, 0x0C CNT, 0x10 SR; 0x14-0x1C are reserved.
module timer_periph #(
  parameter int PSC_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  timer_periph_if.slave  bus,
  output logic           irq
);

  localparam logic [2:0] OFF_CR  = 3'd0;
  localparam logic [2:0] OFF_PSC = 3'd1;
  localparam logic [2:0] OFF_ARR = 3'd2;
  localparam logic [2:0] OFF_CNT = 3'd3;
  localparam logic [2:0] OFF_SR  = 3'd4;

  logic             r_en;
  logic             r_opm;
  logic             r_ie;
  logic             r_uif;
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_cnt;
  logic [31:0]      r_arr;
  logic [31:0]      r_cnt;

  logic        w_wr;
  logic [2:0]  w_off;
  logic        w_wr_cr;
  logic        w_wr_psc;
  logic        w_wr_arr;
  logic        w_wr_cnt;
  logic        w_wr_sr;
  logic        w_tick;
  logic        w_hit;
  logic        w_update;
  logic [31:0] w_psc_ext;
  logic        w_unused_addr;

  assign w_wr     = bus.cs & bus.we;
  assign w_off    = bus.addr[4:2];
  assign w_wr_cr  = w_wr && (w_off == OFF_CR);
  assign w_wr_psc = w_wr && (w_off == OFF_PSC);
  assign w_wr_arr = w_wr && (w_off == OFF_ARR);
  assign w_wr_cnt = w_wr && (w_off == OFF_CNT);
  assign w_wr_sr  = w_wr && (w_off == OFF_SR);

  // Only addr[4:2] selects a register; the remaining offset bits are don't-care.
  assign w_unused_addr = ^{bus.addr[7:5], bus.addr[1:0]};

  // A tick fires on the prescaler's terminal count; a CNT write on the same
  // edge takes the counter over, so the reload compare is dropped then.
  assign w_tick   = r_en && (r_psc_cnt == r_psc);
  assign w_hit    = (r_cnt == r_arr);
  assign w_update = w_tick && w_hit && !w_wr_cnt;

  assign irq = r_uif & r_ie;

  // Zero-extend PSC to the bus width for readback.
  always_comb begin
    w_psc_ext              = '0;
    w_psc_ext[PSC_W-1:0]   = r_psc;
  end

  // Control register; a bus write beats the one-shot auto-clear of EN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en  <= 1'b0;
      r_opm <= 1'b0;
      r_ie  <= 1'b0;
    end else if (w_wr_cr) begin
      r_en  <= bus.wdata[0];
      r_opm <= bus.wdata[1];
      r_ie  <= bus.wdata[2];
    end else if (w_update && r_opm) begin
      r_en  <= 1'b0;
    end
  end

  // Prescaler value and its running counter; a PSC write restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc     <= '0;
      r_psc_cnt <= '0;
    end else begin
      if (w_wr_psc) begin
        r_psc <= bus.wdata[PSC_W-1:0];
      end
      if (w_wr_psc || w_tick) begin
        r_psc_cnt <= '0;
      end else if (r_en) begin
        r_psc_cnt <= r_psc_cnt + 1'b1;
      end
    end
  end

  // Auto-reload limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arr <= 32'hFFFF_FFFF;
    end else if (w_wr_arr) begin
      r_arr <= bus.wdata;
    end
  end

  // Main counter: bus write first, else reload on match or wrap-increment on tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_wr_cnt) begin
      r_cnt <= bus.wdata;
    end else if (w_tick) begin
      r_cnt <= w_hit ? 32'd0 : r_cnt + 32'd1;
    end
  end

  // Sticky update flag; a hardware set outranks a same-edge W1C clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_uif <= 1'b0;
    end else if (w_update) begin
      r_uif <= 1'b1;
    end else if (w_wr_sr && bus.wdata[0]) begin
      r_uif <= 1'b0;
    end
  end

  // Combinational read mux; deselected or reserved offsets return zero.
  always_comb begin
    bus.rdata = 32'd0;
    if (bus.cs) begin
      case (w_off)
        OFF_CR:  bus.rdata = {29'd0, r_ie, r_opm, r_en};
        OFF_PSC: bus.rdata = w_psc_ext;
        OFF_ARR: bus.rdata = r_arr;
        OFF_CNT: bus.rdata = r_cnt;
        OFF_SR:  bus.rdata = {31'd0, r_uif};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

endmodule
